// File: rtl/exec_mem_unit_pkg.sv
// Shared definitions for the execute/memory stage: data width, ALU op encodings
// and the ALU function itself.
package exec_mem_unit_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    // Modulo-256 add/subtract; carry and overflow are deliberately dropped.
    function automatic logic [DATA_W-1:0] alu_calc(input alu_op_e op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return (op == ALU_SUB) ? a - b : a + b;
    endfunction

endpackage

// File: rtl/exec_mem_unit_if.sv
// Bus between the operand muxes / write-back side and the execute/memory stage.
interface exec_mem_unit_if;
    import exec_mem_unit_pkg::*;

    logic              ALUOp;
    logic [DATA_W-1:0] Data1;
    logic [DATA_W-1:0] Data2;
    logic [DATA_W-1:0] Write_Data;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] ALU_Result;
    logic              Zero;
    logic [DATA_W-1:0] Read_Data;
    logic              Clk_Div;
    logic              Tick;

    modport master (
        output ALUOp, Data1, Data2, Write_Data, MemRead, MemWrite,
        input  ALU_Result, Zero, Read_Data, Clk_Div, Tick
    );

    modport slave (
        input  ALUOp, Data1, Data2, Write_Data, MemRead, MemWrite,
        output ALU_Result, Zero, Read_Data, Clk_Div, Tick
    );

endinterface

// File: rtl/data_mem8.sv
// DEPTH x 8 flop-array data memory: reset-to-index contents, one write port and
// a registered read port that returns the pre-write contents.
module data_mem8
    import exec_mem_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic                     re,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            // NOTE: the array is reset on purpose so loads after reset see mem[i]=i;
            // that rules out a RAM macro and keeps this a flop array.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= DATA_W'(i);
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= re ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/slow_clk_gen.sv
// Free-running divider producing the visible step clock and a one-cycle tick
// on each of its rising edges.
module slow_clk_gen #(
    parameter int unsigned DIV_HALF = 25_000_000
) (
    input  logic clk,
    input  logic clear,
    output logic clk_div,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(DIV_HALF - 1);

    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt     <= '0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            clk_div <= ~clk_div;
            // Tick is registered alongside clk_div so both rise on the same edge.
            tick    <= ~clk_div;
        end else begin
            cnt  <= cnt + 32'd1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory stage: registered 8-bit ALU whose result addresses the data
// memory, plus the core's slow step-clock generator.
module exec_mem_unit
    import exec_mem_unit_pkg::*;
#(
    parameter int unsigned DIV_HALF = 25_000_000,
    parameter int unsigned DEPTH    = 32
) (
    input  logic           Clk,
    input  logic           Clear,
    exec_mem_unit_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] alu_next;
    logic [DATA_W-1:0] alu_q;
    logic              zero_q;

    assign alu_next = alu_calc(alu_op_e'(bus.ALUOp), bus.Data1, bus.Data2);

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Clear) begin
            alu_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            alu_q  <= alu_next;
            zero_q <= (alu_next == '0);
        end
    end

    assign bus.ALU_Result = alu_q;
    assign bus.Zero       = zero_q;

    // Low address bits only: addresses alias with period DEPTH.
    data_mem8 #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (Clk),
        .clear(Clear),
        .addr (alu_q[ADDR_W-1:0]),
        .we   (bus.MemWrite),
        .re   (bus.MemRead),
        .wdata(bus.Write_Data),
        .rdata(bus.Read_Data)
    );

    slow_clk_gen #(
        .DIV_HALF(DIV_HALF)
    ) u_div (
        .clk    (Clk),
        .clear  (Clear),
        .clk_div(bus.Clk_Div),
        .tick   (bus.Tick)
    );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Bench for exec_mem_unit: directed vector table, hand-written multi-cycle
// sequences and random traffic, all checked against a cycle-level model.
module tb_exec_mem_unit;

    localparam int DH    = 4;
    localparam int DEPTH = 32;

    logic clk;
    logic clear;

    exec_mem_unit_if bus ();

    exec_mem_unit #(
        .DIV_HALF(DH),
        .DEPTH   (DEPTH)
    ) dut (
        .Clk  (clk),
        .Clear(clear),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state, advanced once per clock from the rules of the stage.
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_alu;
    logic       m_zero;
    logic [7:0] m_rd;
    int         m_k;     // clock edges since reset was last released

    typedef struct {
        logic       op;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] wd;
        logic       re;
        logic       we;
        logic [7:0] e_alu;
        logic       e_zero;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic clr, input logic op, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] wd,
                              input logic re, input logic we);
        int addr;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'(i);
            m_alu  = 8'd0;
            m_zero = 1'b1;
            m_rd   = 8'd0;
            m_k    = 0;
        end else begin
            addr = int'(m_alu) % DEPTH;
            m_rd = re ? m_mem[addr] : 8'd0;
            if (we) m_mem[addr] = wd;
            m_alu  = op ? 8'((int'(d1) - int'(d2) + 256) % 256) : 8'((int'(d1) + int'(d2)) % 256);
            m_zero = (m_alu == 8'd0);
            m_k++;
        end
    endtask

    task automatic step(input logic clr, input logic op, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] wd,
                        input logic re, input logic we);
        clear          = clr;
        bus.ALUOp      = op;
        bus.Data1      = d1;
        bus.Data2      = d2;
        bus.Write_Data = wd;
        bus.MemRead    = re;
        bus.MemWrite   = we;
        @(posedge clk);
        model_edge(clr, op, d1, d2, wd, re, we);
        #1;
        check("alu_result", 32'(bus.ALU_Result), 32'(m_alu));
        check("zero",       32'(bus.Zero),       32'(m_zero));
        check("read_data",  32'(bus.Read_Data),  32'(m_rd));
        check("clk_div",    32'(bus.Clk_Div),    32'((m_k / DH) % 2));
        check("tick",       32'(bus.Tick),       32'((m_k % (2 * DH)) == DH));
    endtask

    initial begin
        int n;
        logic got;

        //               op    d1     d2     wd     re    we    alu    z     rd
        vecs[0]  = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02};
        vecs[2]  = '{1'b1, 8'h05, 8'h07, 8'h00, 1'b1, 1'b0, 8'hFE, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 8'h30, 8'h04, 8'h00, 1'b1, 1'b0, 8'h34, 1'b0, 8'h1E};
        vecs[4]  = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 1'b0, 8'h14};
        vecs[5]  = '{1'b0, 8'h05, 8'h00, 8'hA5, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 8'h25, 8'h00, 8'h00, 1'b1, 1'b0, 8'h25, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 1'b0, 8'h07, 1'b0, 8'hA5};
        vecs[8]  = '{1'b0, 8'h07, 8'h00, 8'h3C, 1'b1, 1'b1, 8'h07, 1'b0, 8'h07};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C};
        vecs[10] = '{1'b1, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};

        clear = 1'b1;
        bus.ALUOp = 1'b0; bus.Data1 = '0; bus.Data2 = '0;
        bus.Write_Data = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        m_k = 0;

        // Reset held two cycles, with garbage operands that must be ignored.
        step(1'b1, 1'b0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0);
        check("rst_alu",     32'(bus.ALU_Result), 32'h0);
        check("rst_zero",    32'(bus.Zero),       32'h1);
        check("rst_rd",      32'(bus.Read_Data),  32'h0);
        check("rst_clk_div", 32'(bus.Clk_Div),    32'h0);

        for (int i = 0; i < 12; i++) begin
            step(1'b0, vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].wd, vecs[i].re, vecs[i].we);
            check($sformatf("vec%0d_alu", i),  32'(bus.ALU_Result), 32'(vecs[i].e_alu));
            check($sformatf("vec%0d_zero", i), 32'(bus.Zero),       32'(vecs[i].e_zero));
            check($sformatf("vec%0d_rd", i),   32'(bus.Read_Data),  32'(vecs[i].e_rd));
        end

        // Clear mid-count, then the first rise must come exactly DH cycles later.
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("div_clear_clk", 32'(bus.Clk_Div), 32'h0);
        check("div_clear_tick", 32'(bus.Tick), 32'h0);
        for (int i = 1; i < DH; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            check($sformatf("div_low%0d", i), 32'(bus.Clk_Div), 32'h0);
        end
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("div_first_rise", 32'(bus.Clk_Div), 32'h1);
        check("div_first_tick", 32'(bus.Tick), 32'h1);

        n = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
            n++;
            if (bus.Tick) got = 1'b1;
        end
        check("div_tick_seen", 32'(got), 32'h1);
        check("div_tick_period", 32'(n), 32'(2 * DH));

        // A store at the same edge as Clear must be discarded.
        step(1'b0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'hEE, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        check("rst_store_rd", 32'(bus.Read_Data), 32'h03);

        // Random traffic; small operands keep addresses colliding often.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d1;
            logic [7:0] d2;
            d1 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            d2 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            step(1'($urandom_range(0, 39) == 0), 1'($urandom), d1, d2, 8'($urandom),
                 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
